// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: MD opcodes,
// latency defaults and opcode classification helpers.
package e_mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  localparam logic [3:0] MULT_CYCLES_DEF = 4'd5;
  localparam logic [3:0] DIV_CYCLES_DEF  = 4'd10;

  // Operations that occupy the unit for several cycles.
  function automatic logic is_long_op(input md_op_e op);
    logic res_s;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: res_s = 1'b1;
      default:                            res_s = 1'b0;
    endcase
    return res_s;
  endfunction

  function automatic logic is_signed_op(input md_op_e op);
    logic res_s;
    case (op)
      MD_MULT, MD_DIV: res_s = 1'b1;
      default:         res_s = 1'b0;
    endcase
    return res_s;
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// Pipeline-side connection of the MD unit: E-stage operands/opcode in,
// HI/LO and hazard signals out.
interface e_mdu_if;
  import e_mdu_pkg::*;

  md_op_e      e_md_op;
  logic [31:0] e_grf_rs;
  logic [31:0] e_grf_rt;
  logic        e_new_instr;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        md_stall_req;

  modport master (
    output e_md_op, e_grf_rs, e_grf_rt, e_new_instr,
    input  hi, lo, busy, md_stall_req
  );

  modport slave (
    input  e_md_op, e_grf_rs, e_grf_rt, e_new_instr,
    output hi, lo, busy, md_stall_req
  );
endinterface

// File: rtl/e_mdu_md_alu.sv
// Combinational arithmetic core: 64-bit product and quotient/remainder.
// Division works on magnitudes so the signed result truncates toward zero.
module e_mdu_md_alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_signed,
  output logic [63:0] prod,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        div_zero
);

  logic [63:0] a_ext_s;
  logic [63:0] b_ext_s;
  logic        a_neg_s;
  logic        b_neg_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [31:0] q_mag_s;
  logic [31:0] r_mag_s;

  // Low 64 bits of the product of the extended operands are exact for both signednesses.
  always_comb begin
    a_ext_s = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    b_ext_s = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    prod    = a_ext_s * b_ext_s;
  end

  // Magnitude divide, then restore signs; 0x80000000 magnitude stays representable unsigned.
  always_comb begin
    a_neg_s  = is_signed & a[31];
    b_neg_s  = is_signed & b[31];
    a_mag_s  = a_neg_s ? (32'd0 - a) : a;
    b_mag_s  = b_neg_s ? (32'd0 - b) : b;
    div_zero = (b == 32'd0);
    if (div_zero) begin
      q_mag_s = 32'd0;
      r_mag_s = 32'd0;
    end else begin
      q_mag_s = a_mag_s / b_mag_s;
      r_mag_s = a_mag_s % b_mag_s;
    end
    quot = (a_neg_s ^ b_neg_s) ? (32'd0 - q_mag_s) : q_mag_s;
    rem  = a_neg_s ? (32'd0 - r_mag_s) : r_mag_s;
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit owning HI/LO. Results are computed at issue,
// held pending, and committed when the latency counter expires.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter logic [3:0] MULT_CYCLES = MULT_CYCLES_DEF,
  parameter logic [3:0] DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic    clk,
  input logic    reset,
  e_mdu_if.slave bus
);

  logic [3:0]  cnt_r,     cnt_s;
  logic [31:0] pend_hi_r, pend_hi_s;
  logic [31:0] pend_lo_r, pend_lo_s;
  logic        pend_wr_r, pend_wr_s;
  logic [31:0] hi_r,      hi_s;
  logic [31:0] lo_r,      lo_s;

  logic        busy_s;
  logic        accept_s;
  logic [63:0] prod_s;
  logic [31:0] quot_s;
  logic [31:0] rem_s;
  logic        div_zero_s;

  e_mdu_md_alu u_md_alu (
    .a         (bus.e_grf_rs),
    .b         (bus.e_grf_rt),
    .is_signed (is_signed_op(bus.e_md_op)),
    .prod      (prod_s),
    .quot      (quot_s),
    .rem       (rem_s),
    .div_zero  (div_zero_s)
  );

  // Hazard-facing status: stall while busy and in the issue cycle of a long op.
  always_comb begin
    busy_s           = (cnt_r != 4'd0);
    accept_s         = bus.e_new_instr & ~busy_s;
    bus.busy         = busy_s;
    bus.md_stall_req = busy_s | (accept_s & is_long_op(bus.e_md_op));
    bus.hi           = hi_r;
    bus.lo           = lo_r;
  end

  // Next-state: count down / commit while busy, otherwise decode a new op.
  always_comb begin
    cnt_s     = cnt_r;
    pend_hi_s = pend_hi_r;
    pend_lo_s = pend_lo_r;
    pend_wr_s = pend_wr_r;
    hi_s      = hi_r;
    lo_s      = lo_r;
    if (busy_s) begin
      if (cnt_r == 4'd1) begin
        cnt_s = 4'd0;
        if (pend_wr_r) begin
          hi_s = pend_hi_r;
          lo_s = pend_lo_r;
        end else begin
          hi_s = hi_r;
        end
      end else begin
        cnt_s = cnt_r - 4'd1;
      end
    end else if (accept_s) begin
      case (bus.e_md_op)
        MD_MULT, MD_MULTU: begin
          cnt_s     = MULT_CYCLES;
          pend_hi_s = prod_s[63:32];
          pend_lo_s = prod_s[31:0];
          pend_wr_s = 1'b1;
        end
        MD_DIV, MD_DIVU: begin
          cnt_s     = DIV_CYCLES;
          pend_hi_s = rem_s;
          pend_lo_s = quot_s;
          pend_wr_s = ~div_zero_s;
        end
        MD_MTHI: hi_s = bus.e_grf_rs;
        MD_MTLO: lo_s = bus.e_grf_rs;
        default: cnt_s = cnt_r;
      endcase
    end else begin
      cnt_s = cnt_r;
    end
  end

  // State registers; reset drops any pending result immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r     <= 4'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_wr_r <= 1'b0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
    end else begin
      cnt_r     <= cnt_s;
      pend_hi_r <= pend_hi_s;
      pend_lo_r <= pend_lo_s;
      pend_wr_r <= pend_wr_s;
      hi_r      <= hi_s;
      lo_r      <= lo_s;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu: latency, signed/unsigned results,
// divide-by-zero, MTHI/MTLO, busy-time ignore, async reset and bubbles.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  e_mdu_if bus ();

  e_mdu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input md_op_e op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic nw);
    bus.e_md_op     = op;
    bus.e_grf_rs    = rs;
    bus.e_grf_rt    = rt;
    bus.e_new_instr = nw;
    #1;
  endtask

  task automatic idle();
    drive(MD_NONE, 32'd0, 32'd0, 1'b0);
  endtask

  // Issue a long op, check busy for the expected cycles, then hi/lo.
  task automatic long_op(input string tag, input md_op_e op, input logic [31:0] rs,
                         input logic [31:0] rt, input int cycles,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    drive(op, rs, rt, 1'b1);
    chk({tag, "_stall_issue"}, {31'd0, bus.md_stall_req}, 32'd1);
    step();
    idle();
    for (int i = 0; i < cycles; i++) begin
      chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
      chk({tag, "_stall_busy"}, {31'd0, bus.md_stall_req}, 32'd1);
      step();
    end
    chk({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_hi"}, bus.hi, exp_hi);
    chk({tag, "_lo"}, bus.lo, exp_lo);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    idle();
    step();
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_stall", {31'd0, bus.md_stall_req}, 32'd0);
    reset = 1'b0;
    step();

    long_op("mult",  MD_MULT,  32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    long_op("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
    long_op("div",   MD_DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    long_op("divu0", MD_DIVU,  32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    long_op("divs0", MD_DIV,   32'hFFFF_FFF9, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    long_op("divovf", MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    long_op("divpos", MD_DIV,  32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    long_op("divu",   MD_DIVU, 32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0001, 32'h7FFF_FFFC);

    // MTHI then MTLO: immediate, no busy, no stall.
    drive(MD_MTHI, 32'h0000_1234, 32'd0, 1'b1);
    chk("mthi_stall", {31'd0, bus.md_stall_req}, 32'd0);
    step();
    chk("mthi_hi", bus.hi, 32'h0000_1234);
    chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
    drive(MD_MTLO, 32'h0000_5678, 32'd0, 1'b1);
    step();
    idle();
    chk("mt_hi", bus.hi, 32'h0000_1234);
    chk("mt_lo", bus.lo, 32'h0000_5678);
    chk("mt_busy", {31'd0, bus.busy}, 32'd0);

    // DIV 100/7 with a MULT and an MTHI held on the inputs while busy.
    drive(MD_DIV, 32'd100, 32'd7, 1'b1);
    step();
    drive(MD_MULT, 32'd5, 32'd5, 1'b1);
    for (int i = 0; i < 9; i++) begin
      chk("ign_stall", {31'd0, bus.md_stall_req}, 32'd1);
      step();
    end
    drive(MD_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b1);
    step();
    idle();
    chk("ign_busy", {31'd0, bus.busy}, 32'd0);
    chk("ign_hi", bus.hi, 32'd2);
    chk("ign_lo", bus.lo, 32'd14);

    // Async reset in the middle of a DIV.
    drive(MD_DIV, 32'd100, 32'd7, 1'b1);
    step();
    idle();
    step();
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("rmid_busy", {31'd0, bus.busy}, 32'd0);
    chk("rmid_hi", bus.hi, 32'd0);
    chk("rmid_lo", bus.lo, 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("rmid_late_hi", bus.hi, 32'd0);
    chk("rmid_late_lo", bus.lo, 32'd0);
    chk("rmid_late_busy", {31'd0, bus.busy}, 32'd0);

    // Bubble: MULT with e_new_instr low has no effect.
    drive(MD_MTLO, 32'h0000_00AA, 32'd0, 1'b1);
    step();
    drive(MD_MULT, 32'd9, 32'd9, 1'b0);
    chk("bub_stall", {31'd0, bus.md_stall_req}, 32'd0);
    step();
    chk("bub_busy", {31'd0, bus.busy}, 32'd0);
    idle();
    for (int i = 0; i < 6; i++) step();
    chk("bub_hi", bus.hi, 32'd0);
    chk("bub_lo", bus.lo, 32'h0000_00AA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
